// File: rtl/alu_pkg.sv
// ALU op-code definitions shared by the decoder, the ALU and the ALU arbiter.
package alu_pkg;

  localparam int unsigned ALU_OP_W    = 4;
  localparam int unsigned ALU_OP_LAST = 9;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  // Codes above ALU_OP_LAST are reserved and must never reach the ALU.
  function automatic logic op_legal(input int unsigned op);
    return op <= ALU_OP_LAST;
  endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response register: loads on grant, drains on valid/ready handshake.
module alu_rsp_slot #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             err_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             err_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             err_q, err_d;

  // A load in the same cycle as a drain wins, giving drain-and-refill.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      err_d   = err_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between the execute path (0)
// and the address/branch-target path (1), with a one-entry response slot each.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,

  output logic [WIDTH-1:0] alumux1_out,
  output logic [WIDTH-1:0] alumux2_out,
  output logic [OPW-1:0]   aluop,
  input  logic [WIDTH-1:0] aluout
);

  logic             elig0, elig1;
  logic             grant0, grant1;
  logic             legal0, legal1;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] slot0_data, slot1_data;

  assign legal0 = op_legal(32'(req0_op));
  assign legal1 = op_legal(32'(req1_op));

  // A full slot stays eligible when it is being drained this very cycle.
  always_comb begin
    elig0  = !rst && req0_valid && (!rsp0_valid || rsp0_ready);
    elig1  = !rst && req1_valid && (!rsp1_valid || rsp1_ready);
    // last_grant_q == 1 means requester 1 went last, so requester 0 wins a tie.
    grant0 = elig0 && (!elig1 || last_grant_q);
    grant1 = elig1 && (!elig0 || !last_grant_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Idle and illegal-op cycles present ADD 0+0 so the ALU inputs stay quiet.
  always_comb begin
    alumux1_out = '0;
    alumux2_out = '0;
    aluop       = '0;
    if (grant0 && legal0) begin
      alumux1_out = req0_a;
      alumux2_out = req0_b;
      aluop       = req0_op;
    end else if (grant1 && legal1) begin
      alumux1_out = req1_a;
      alumux2_out = req1_b;
      aluop       = req1_op;
    end
  end

  assign slot0_data = legal0 ? aluout : '0;
  assign slot1_data = legal1 ? aluout : '0;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0) begin
      last_grant_d = 1'b0;
    end else if (grant1) begin
      last_grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  alu_rsp_slot #(
    .Width (WIDTH)
  ) u_slot0 (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (grant0),
    .data_i  (slot0_data),
    .err_i   (!legal0),
    .ready_i (rsp0_ready),
    .valid_o (rsp0_valid),
    .data_o  (rsp0_data),
    .err_o   (rsp0_err)
  );

  alu_rsp_slot #(
    .Width (WIDTH)
  ) u_slot1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (grant1),
    .data_i  (slot1_data),
    .err_i   (!legal1),
    .ready_i (rsp1_ready),
    .valid_o (rsp1_valid),
    .data_o  (rsp1_data),
    .err_o   (rsp1_err)
  );

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single-cycle ALU between two requesters: port 0 is the execute path and port 1 is the address/branch-target path. Each requester uses a valid/ready request channel and a valid/ready response channel. The arbiter grants at most one operation per cycle with round-robin fairness and drives the ALU operand and op inputs. It captures the ALU result into a one-entry response slot per requester.

Parameters:
WIDTH, 32, operand/result width
OPW, 4, ALU op-code width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req0_op  in  OPW  ALU op (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU)
rsp0_valid  out  1  response 0 slot full
rsp0_ready  in  1  requester 0 consumes response
rsp0_data  out  WIDTH  captured result
rsp0_err  out  1  op was illegal (10..15)
req1_*/rsp1_*  same set for requester 1
alumux1_out  out  WIDTH  to ALU operand A
alumux2_out  out  WIDTH  to ALU operand B
aluop  out  OPW  to ALU op select
aluout  in  WIDTH  ALU result (combinational from the three outputs above)

Behaviour:
- Eligibility: requester i is eligible when reqi_valid=1 and one of these holds:
  - its slot is empty, or
  - rspi_valid and rspi_ready are both 1 this cycle (drain and refill in the same cycle).
- Grant:
  - One eligible requester: it is granted.
  - Both eligible: the one not granted last wins.
  - reqi_ready = granti, combinational from the current inputs and state.
- Round-robin state: 1-bit last_grant.
  - Updates only on a grant.
  - Reset value 1, so requester 0 wins the first tie.
- ALU drive, combinational:
  - On grant: alumux1_out/alumux2_out/aluop = granted a/b/op.
  - Otherwise: all zero (ADD 0+0), to avoid toggling.
- Illegal op (op >= 10):
  - The ALU is driven with zeros, not the request.
  - The slot captures data=0, err=1.
  - Counts as a grant; the round-robin pointer advances.
- Capture: on the grant edge the slot loads aluout (err=0). rspi_valid rises the next cycle, so request-to-response latency is 1 cycle.
- Hold: the slot holds data, err and valid stable while rspi_valid=1 and rspi_ready=0.
- Drain: rspi_valid=1 with rspi_ready=1 and no refill clears the slot on the next edge.
- Back-pressure: a full, undrained slot blocks only its own requester. The other requester may be granted every cycle.
- Throughput: 1 op/cycle total. Under continuous contention with both responses drained, grants alternate 0,1,0,1.
- Request stability: a requester holding valid with ready=0 must keep a/b/op stable. The arbiter does not check this.
- Reset:
  - All slot valid, data and err bits clear to 0; last_grant=1.
  - reqi_ready=0 while rst=1; ALU inputs are zero.
  - Reset mid-operation discards all in-flight results; requesters reissue.
- No combinational path from rspi_ready to anything except reqi_ready and the grant (drain-refill).

Decomposition:
- Shared package alu_pkg:
  - Op constants ALU_ADD=0 … ALU_SLTU=9.
  - ALU_OP_LAST=9 and an alu_op_t typedef.
  - This package is reused by the decoder and the ALU itself.
- Sub-module alu_rsp_slot:
  - One-entry response register with load/drain and data/err/valid.
  - Instantiated twice.
- Grant logic and last_grant stay in the top level.

Test Plan:
- Single request: req0 ADD a=5 b=7, rsp0_ready=1 → req0_ready=1 in cycle N; rsp0_valid=1, data=12, err=0 in N+1; slot empty in N+2.
- Tie after reset: req0 SUB 10,3 and req1 SRA 0x80000000,4 both valid → cycle N grants 0 (rsp0 data=7); N+1 grants 1 (rsp1 data=0xF8000000).
- Back-pressure: rsp0_ready=0 with rsp0 full and req0 valid → req0_ready=0 and rsp0_data stable for 5 cycles. Meanwhile req1 SLTU 1,0xFFFFFFFF is granted every cycle with data=1. Raising rsp0_ready gives drain and refill of slot 0 in the same cycle.
- Illegal op: req1 op=4'hC, a=0xDEAD → granted; aluop=0 and alumux1_out=0 that cycle; rsp1 data=0, err=1.
- Sustained contention: both valid with alternating ops for 8 cycles, both rsp_ready=1 → grants strictly alternate; every response matches the ALU reference model (SLT 0xFFFFFFFF,1 → 1; SLL 1,33 → 2).
- Reset mid-operation: assert rst in the cycle after a grant with rsp0 full → next cycle rsp0_valid=0, rsp1_valid=0, req ready=0; after release a tie grants requester 0 first.
